// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory bus arbiter:
// bus command encoding, transaction owner and tag-table entry.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_cmd_e;

    typedef enum logic {
        OWN_DC = 1'b0,
        OWN_IC = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   stale;
    } tag_entry_t;

    localparam tag_entry_t ENTRY_EMPTY = '{
        valid: 1'b0,
        owner: OWN_DC,
        stale: 1'b0
    };

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of requester, memory-bus and response signals.
// master: arbiter side; slave: caches/memory side.
interface dmem_arbiter_if #(
    parameter int TAG_W = 4
);
    logic             dc_req_i;
    logic [1:0]       dc_cmd_i;
    logic [63:0]      dc_addr_i;
    logic [63:0]      dc_data_i;
    logic             dc_gnt_o;
    logic [TAG_W-1:0] dc_tag_o;
    logic             dc_rsp_vld_o;
    logic [TAG_W-1:0] dc_rsp_tag_o;
    logic [63:0]      dc_rsp_data_o;

    logic             ic_req_i;
    logic [63:0]      ic_addr_i;
    logic             ic_flush_i;
    logic             ic_gnt_o;
    logic [TAG_W-1:0] ic_tag_o;
    logic             ic_rsp_vld_o;
    logic [TAG_W-1:0] ic_rsp_tag_o;
    logic [63:0]      ic_rsp_data_o;

    logic [1:0]       proc2mem_command_o;
    logic [63:0]      proc2mem_addr_o;
    logic [63:0]      proc2mem_data_o;
    logic [TAG_W-1:0] mem2proc_response_i;
    logic [63:0]      mem2proc_data_i;
    logic [TAG_W-1:0] mem2proc_tag_i;

    modport master (
        input  dc_req_i, dc_cmd_i, dc_addr_i, dc_data_i,
        output dc_gnt_o, dc_tag_o,
        output dc_rsp_vld_o, dc_rsp_tag_o, dc_rsp_data_o,
        input  ic_req_i, ic_addr_i, ic_flush_i,
        output ic_gnt_o, ic_tag_o,
        output ic_rsp_vld_o, ic_rsp_tag_o, ic_rsp_data_o,
        output proc2mem_command_o, proc2mem_addr_o,
        output proc2mem_data_o,
        input  mem2proc_response_i, mem2proc_data_i,
        input  mem2proc_tag_i
    );

    modport slave (
        output dc_req_i, dc_cmd_i, dc_addr_i, dc_data_i,
        input  dc_gnt_o, dc_tag_o,
        input  dc_rsp_vld_o, dc_rsp_tag_o, dc_rsp_data_o,
        output ic_req_i, ic_addr_i, ic_flush_i,
        input  ic_gnt_o, ic_tag_o,
        input  ic_rsp_vld_o, ic_rsp_tag_o, ic_rsp_data_o,
        input  proc2mem_command_o, proc2mem_addr_o,
        input  proc2mem_data_o,
        output mem2proc_response_i, mem2proc_data_i,
        output mem2proc_tag_i
    );

endinterface

// File: rtl/dmem_tag_table.sv
// Owner table indexed by memory tag.
// Ports: clk/rst; alloc_* write; lookup_* read + clear; flush marks IC stale.
module dmem_tag_table
    import dmem_arbiter_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_en,
    input  logic [TAG_W-1:0] alloc_tag,
    input  owner_e           alloc_owner,
    input  logic             alloc_stale,
    input  logic [TAG_W-1:0] lookup_tag,
    output tag_entry_t       lookup_entry,
    input  logic             clear_en,
    input  logic             flush
);
    localparam int DEPTH = 1 << TAG_W;

    tag_entry_t entries_q [DEPTH];

    assign lookup_entry = entries_q[lookup_tag];

    // Later assignments win: flush, then clear, then allocate,
    // so a tag returned and re-issued together keeps the new owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= ENTRY_EMPTY;
            end
        end else begin
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (entries_q[i].valid &&
                        entries_q[i].owner == OWN_IC) begin
                        entries_q[i].stale <= 1'b1;
                    end
                end
            end
            if (clear_en) begin
                entries_q[lookup_tag] <= ENTRY_EMPTY;
            end
            if (alloc_en) begin
                entries_q[alloc_tag] <= '{
                    valid: 1'b1,
                    owner: alloc_owner,
                    stale: alloc_stale
                };
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates Icache miss path and Dcache MSHR onto one memory bus.
// Ports: clk, rst (sync, active-high), bus (dmem_arbiter_if.master).
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int STARVE_LIM = 4,
    parameter int TAG_W      = 4
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.master bus
);
    localparam int CNT_W = $clog2(STARVE_LIM + 1);
    localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

    logic [CNT_W-1:0] starve_cnt;
    logic             sel_dc;
    logic             sel_ic;
    logic             accepted;
    logic             dc_gnt;
    logic             ic_gnt;
    logic             alloc_en;
    owner_e           alloc_owner;
    logic             hit;
    logic             live;
    tag_entry_t       entry;

    // Dcache wins ties until the Icache has waited STARVE_LIM cycles.
    always_comb begin
        sel_ic = bus.ic_req_i &&
                 (!bus.dc_req_i || starve_cnt >= LIM);
        sel_dc = bus.dc_req_i && !sel_ic;
    end

    assign accepted = bus.mem2proc_response_i != '0;
    assign dc_gnt   = sel_dc && accepted;
    assign ic_gnt   = sel_ic && accepted;

    always_comb begin
        bus.proc2mem_command_o = BUS_NONE;
        bus.proc2mem_addr_o    = '0;
        bus.proc2mem_data_o    = '0;
        if (sel_dc) begin
            bus.proc2mem_command_o = bus.dc_cmd_i;
            bus.proc2mem_addr_o    = bus.dc_addr_i;
            bus.proc2mem_data_o    = bus.dc_data_i;
        end else if (sel_ic) begin
            bus.proc2mem_command_o = BUS_LOAD;
            bus.proc2mem_addr_o    = bus.ic_addr_i;
        end
    end

    assign bus.dc_gnt_o = dc_gnt;
    assign bus.ic_gnt_o = ic_gnt;
    assign bus.dc_tag_o = dc_gnt ? bus.mem2proc_response_i : '0;
    assign bus.ic_tag_o = ic_gnt ? bus.mem2proc_response_i : '0;

    // Stores need no response, so only loads claim a tag.
    assign alloc_en = ic_gnt ||
                      (dc_gnt && bus.dc_cmd_i == BUS_LOAD);
    assign alloc_owner = ic_gnt ? OWN_IC : OWN_DC;

    dmem_tag_table #(
        .TAG_W (TAG_W)
    ) u_tag_table (
        .clk          (clk),
        .rst          (rst),
        .alloc_en     (alloc_en),
        .alloc_tag    (bus.mem2proc_response_i),
        .alloc_owner  (alloc_owner),
        .alloc_stale  (ic_gnt && bus.ic_flush_i),
        .lookup_tag   (bus.mem2proc_tag_i),
        .lookup_entry (entry),
        .clear_en     (hit),
        .flush        (bus.ic_flush_i)
    );

    // A flush in the same cycle kills an IC response in flight.
    always_comb begin
        hit  = bus.mem2proc_tag_i != '0 && entry.valid;
        live = hit && !entry.stale &&
               !(entry.owner == OWN_IC && bus.ic_flush_i);
    end

    always_comb begin
        bus.dc_rsp_vld_o  = live && entry.owner == OWN_DC;
        bus.ic_rsp_vld_o  = live && entry.owner == OWN_IC;
        bus.dc_rsp_tag_o  = '0;
        bus.dc_rsp_data_o = '0;
        bus.ic_rsp_tag_o  = '0;
        bus.ic_rsp_data_o = '0;
        if (bus.dc_rsp_vld_o) begin
            bus.dc_rsp_tag_o  = bus.mem2proc_tag_i;
            bus.dc_rsp_data_o = bus.mem2proc_data_i;
        end
        if (bus.ic_rsp_vld_o) begin
            bus.ic_rsp_tag_o  = bus.mem2proc_tag_i;
            bus.ic_rsp_data_o = bus.mem2proc_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!bus.ic_req_i || ic_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt < LIM) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule
